decode_issue_scoreboard: RTL and testbench

Issue controller for the decode stage. It tracks in-flight register writes (per-register pending counters) and in-flight condition-code producers. It grants or stalls each decoded instruction and sequences the branch/jump shadow toward fetch. It sits beside the register file in decode: decode presents source/destination indices, and writeback retires them.

---
 rtl/decode_issue_scoreboard_pkg.sv | 16 +
 rtl/decode_issue_scoreboard_pending_counter_array.sv | 56 +++++
 rtl/decode_issue_scoreboard.sv | 132 +++++++++++++
 tb/tb_decode_issue_scoreboard.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/decode_issue_scoreboard_pkg.sv
// rtl/decode_issue_scoreboard_pkg.sv - shared sizes and FSM encoding for the decode issue scoreboard
package decode_issue_scoreboard_pkg;

  localparam int NUM_REGS  = 16;
  localparam int REG_IDX_W = 4;
  localparam int PEND_W    = 2;
  localparam int CC_PEND_W = 3;
  localparam int BR_SHADOW = 3;
  localparam int SHADOW_W  = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SHADOW = 1'b1
  } issue_state_e;

endpackage

// File: rtl/decode_issue_scoreboard_pending_counter_array.sv
// rtl/decode_issue_scoreboard_pending_counter_array.sv - per-register saturating pending-write counters
module decode_issue_scoreboard_pending_counter_array
  import decode_issue_scoreboard_pkg::*;
(
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             en,
  input  logic                             inc_valid,
  input  logic [REG_IDX_W-1:0]             inc_idx,
  input  logic                             dec_valid,
  input  logic [REG_IDX_W-1:0]             dec_idx,
  output logic [NUM_REGS-1:0][PEND_W-1:0]  pend,
  output logic [NUM_REGS-1:0]              pend_mask,
  output logic                             underflow
);

  localparam logic [PEND_W-1:0] PEND_MAX = '1;

  logic [NUM_REGS-1:0][PEND_W-1:0] pend_next;
  logic [NUM_REGS-1:0]             mask_next;
  logic [NUM_REGS-1:0]             inc_hit;
  logic [NUM_REGS-1:0]             dec_hit;

  // A retire to an idle register is an underflow and never decrements
  assign underflow = dec_valid && (pend[dec_idx] == '0);

  // Next counter values; matching increment and decrement cancel out
  always_comb begin
    pend_next = pend;
    mask_next = '0;
    inc_hit   = '0;
    dec_hit   = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      inc_hit[r] = inc_valid && (inc_idx == REG_IDX_W'(r));
      dec_hit[r] = dec_valid && (dec_idx == REG_IDX_W'(r)) && (pend[r] != '0);
      if (inc_hit[r] && !dec_hit[r]) begin
        if (pend[r] != PEND_MAX) pend_next[r] = pend[r] + PEND_W'(1);
      end else if (dec_hit[r] && !inc_hit[r]) begin
        pend_next[r] = pend[r] - PEND_W'(1);
      end
      mask_next[r] = (pend_next[r] != '0);
    end
  end

  // Counter and mask registers, frozen while the pipeline is disabled
  always_ff @(posedge clk) begin
    if (rst) begin
      pend      <= '0;
      pend_mask <= '0;
    end else if (en) begin
      pend      <= pend_next;
      pend_mask <= mask_next;
    end
  end

endmodule

// File: rtl/decode_issue_scoreboard.sv
// rtl/decode_issue_scoreboard.sv - decode issue grant/stall and branch shadow control (optional WRITEBACK_BYPASS_EN)
module decode_issue_scoreboard
  import decode_issue_scoreboard_pkg::*;
(
  input  logic                  I_CLOCK,
  input  logic                  I_RESET,
  input  logic                  I_LOCK,
  input  logic                  I_IssueValid,
  input  logic                  I_Src1Used,
  input  logic [REG_IDX_W-1:0]  I_Src1Idx,
  input  logic                  I_Src2Used,
  input  logic [REG_IDX_W-1:0]  I_Src2Idx,
  input  logic                  I_DestWrite,
  input  logic [REG_IDX_W-1:0]  I_DestIdx,
  input  logic                  I_IsBranch,
  input  logic                  I_NeedsCC,
  input  logic                  I_WriteBackEnable,
  input  logic [REG_IDX_W-1:0]  I_WriteBackRegIdx,
  input  logic                  I_BranchResolved,
  output logic                  O_IssueGrant,
  output logic                  O_DepStallSignal,
  output logic                  O_BranchStallSignal,
  output logic [NUM_REGS-1:0]   O_PendingMask,
  output logic                  O_Error
);

  localparam logic [PEND_W-1:0]    PEND_MAX = '1;
  localparam logic [CC_PEND_W-1:0] CC_MAX   = '1;

  logic [NUM_REGS-1:0][PEND_W-1:0] pend;
  logic [CC_PEND_W-1:0]            cc_pend;
  issue_state_e                    state, state_next;
  logic [SHADOW_W-1:0]             shadow_cnt, shadow_cnt_next;
  logic                            reg_underflow, cc_underflow;
  logic                            src1_byp, src2_byp, cc_byp;
  logic                            hazard, idle, grant, cc_inc, cc_dec;

`ifdef WRITEBACK_BYPASS_EN
  // The retiring write reaches the register file this cycle, so the last pending write no longer blocks readers
  assign src1_byp = I_WriteBackEnable && (I_WriteBackRegIdx == I_Src1Idx) && (pend[I_Src1Idx] == PEND_W'(1));
  assign src2_byp = I_WriteBackEnable && (I_WriteBackRegIdx == I_Src2Idx) && (pend[I_Src2Idx] == PEND_W'(1));
  assign cc_byp   = I_WriteBackEnable && (cc_pend == CC_PEND_W'(1));
`else
  assign src1_byp = 1'b0;
  assign src2_byp = 1'b0;
  assign cc_byp   = 1'b0;
`endif

  assign hazard = (I_Src1Used  && (pend[I_Src1Idx] != '0) && !src1_byp) ||
                  (I_Src2Used  && (pend[I_Src2Idx] != '0) && !src2_byp) ||
                  (I_DestWrite && (pend[I_DestIdx] == PEND_MAX))        ||
                  (I_NeedsCC   && (cc_pend != '0) && !cc_byp);

  assign idle                = (state == ST_IDLE);
  assign grant               = I_LOCK && I_IssueValid && !hazard && idle;
  assign O_IssueGrant        = grant;
  assign O_DepStallSignal    = I_LOCK && I_IssueValid && hazard && idle;
  assign O_BranchStallSignal = I_LOCK && (!idle || (I_IssueValid && I_IsBranch));

  assign cc_underflow = I_WriteBackEnable && (cc_pend == '0);
  assign cc_inc       = grant && I_DestWrite;
  assign cc_dec       = I_WriteBackEnable && !cc_underflow;

  decode_issue_scoreboard_pending_counter_array u_pend (
    .clk       (I_CLOCK),
    .rst       (I_RESET),
    .en        (I_LOCK),
    .inc_valid (grant && I_DestWrite),
    .inc_idx   (I_DestIdx),
    .dec_valid (I_WriteBackEnable),
    .dec_idx   (I_WriteBackRegIdx),
    .pend      (pend),
    .pend_mask (O_PendingMask),
    .underflow (reg_underflow)
  );

  // Condition-code producer count: every granted register writer sets CC, every retire clears one
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      cc_pend <= '0;
    end else if (I_LOCK) begin
      if (cc_inc && !cc_dec) begin
        if (cc_pend != CC_MAX) cc_pend <= cc_pend + CC_PEND_W'(1);
      end else if (cc_dec && !cc_inc) begin
        cc_pend <= cc_pend - CC_PEND_W'(1);
      end
    end
  end

  // Sticky error on any retire that finds nothing outstanding
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      O_Error <= 1'b0;
    end else if (I_LOCK && (reg_underflow || cc_underflow)) begin
      O_Error <= 1'b1;
    end
  end

  // Branch shadow state register
  always_ff @(posedge I_CLOCK) begin
    if (I_RESET) begin
      state      <= ST_IDLE;
      shadow_cnt <= '0;
    end else if (I_LOCK) begin
      state      <= state_next;
      shadow_cnt <= shadow_cnt_next;
    end
  end

  // Shadow sequencing: enter on a granted branch, leave on countdown expiry or early resolution
  always_comb begin
    state_next      = state;
    shadow_cnt_next = shadow_cnt;
    case (state)
      ST_IDLE: begin
        if (grant && I_IsBranch) begin
          state_next      = ST_SHADOW;
          shadow_cnt_next = SHADOW_W'(BR_SHADOW - 1);
        end
      end
      ST_SHADOW: begin
        if (I_BranchResolved || (shadow_cnt == '0)) begin
          state_next      = ST_IDLE;
          shadow_cnt_next = '0;
        end else begin
          shadow_cnt_next = shadow_cnt - SHADOW_W'(1);
        end
      end
    endcase
  end

endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// tb/tb_decode_issue_scoreboard.sv - self-checking bench for decode_issue_scoreboard
module tb_decode_issue_scoreboard;

`ifdef WRITEBACK_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        I_CLOCK = 1'b0;
  logic        I_RESET, I_LOCK, I_IssueValid, I_Src1Used, I_Src2Used, I_DestWrite;
  logic [3:0]  I_Src1Idx, I_Src2Idx, I_DestIdx, I_WriteBackRegIdx;
  logic        I_IsBranch, I_NeedsCC, I_WriteBackEnable, I_BranchResolved;
  logic        O_IssueGrant, O_DepStallSignal, O_BranchStallSignal, O_Error;
  logic [15:0] O_PendingMask;

  decode_issue_scoreboard dut (
    .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK), .I_IssueValid(I_IssueValid),
    .I_Src1Used(I_Src1Used), .I_Src1Idx(I_Src1Idx), .I_Src2Used(I_Src2Used), .I_Src2Idx(I_Src2Idx),
    .I_DestWrite(I_DestWrite), .I_DestIdx(I_DestIdx), .I_IsBranch(I_IsBranch), .I_NeedsCC(I_NeedsCC),
    .I_WriteBackEnable(I_WriteBackEnable), .I_WriteBackRegIdx(I_WriteBackRegIdx),
    .I_BranchResolved(I_BranchResolved), .O_IssueGrant(O_IssueGrant),
    .O_DepStallSignal(O_DepStallSignal), .O_BranchStallSignal(O_BranchStallSignal),
    .O_PendingMask(O_PendingMask), .O_Error(O_Error)
  );

  always #5 I_CLOCK = ~I_CLOCK;

  typedef struct {
    logic rst, lock, valid, s1u; logic [3:0] s1; logic s2u; logic [3:0] s2;
    logic dw; logic [3:0] d; logic br, ncc, wbe; logic [3:0] wbi; logic res;
    logic e_grant, e_dep, e_brs;
  } vec_t;

  int total = 0;
  int bad   = 0;

  int pend_m[16];
  int cc_m;
  bit err_m;
  int sh_m;

  function automatic vec_t mk(input int rst, lock, valid, s1u, s1, s2u, s2, dw, d,
                              input int br, ncc, wbe, wbi, res, eg, ed, eb);
    vec_t v;
    v.rst = (rst != 0); v.lock = (lock != 0); v.valid = (valid != 0);
    v.s1u = (s1u != 0); v.s1 = 4'(s1); v.s2u = (s2u != 0); v.s2 = 4'(s2);
    v.dw = (dw != 0); v.d = 4'(d); v.br = (br != 0); v.ncc = (ncc != 0);
    v.wbe = (wbe != 0); v.wbi = 4'(wbi); v.res = (res != 0);
    v.e_grant = (eg != 0); v.e_dep = (ed != 0); v.e_brs = (eb != 0);
    return v;
  endfunction

  function automatic vec_t nop();
    return mk(0,1,0, 0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0);
  endfunction

  function automatic vec_t op(input int s1u, s1, s2u, s2, dw, d, br, ncc, wbe, wbi);
    return mk(0,1,1, s1u,s1,s2u,s2, dw,d, br,ncc, wbe,wbi,0, 0,0,0);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decisions from the scoreboard rules applied to the model state
  function automatic void model_comb(input vec_t v, output bit g, output bit d, output bit b);
    bit hz;
    bit idle;
    idle = (sh_m == 0);
    hz = 1'b0;
    if (v.s1u && pend_m[v.s1] > 0 && !(BYP && v.wbe && v.wbi == v.s1 && pend_m[v.s1] == 1)) hz = 1'b1;
    if (v.s2u && pend_m[v.s2] > 0 && !(BYP && v.wbe && v.wbi == v.s2 && pend_m[v.s2] == 1)) hz = 1'b1;
    if (v.dw && pend_m[v.d] == 3) hz = 1'b1;
    if (v.ncc && cc_m > 0 && !(BYP && v.wbe && cc_m == 1)) hz = 1'b1;
    g = v.lock && v.valid && !hz && idle;
    d = v.lock && v.valid && hz && idle;
    b = v.lock && (!idle || (v.valid && v.br));
  endfunction

  function automatic void model_clock(input vec_t v, input bit g);
    int n;
    int inc;
    int dec;
    if (v.rst) begin
      for (int r = 0; r < 16; r++) pend_m[r] = 0;
      cc_m = 0; err_m = 1'b0; sh_m = 0;
      return;
    end
    if (!v.lock) return;
    if (v.wbe && (pend_m[v.wbi] == 0 || cc_m == 0)) err_m = 1'b1;
    for (int r = 0; r < 16; r++) begin
      inc = (g && v.dw && int'(v.d) == r) ? 1 : 0;
      dec = (v.wbe && int'(v.wbi) == r && pend_m[r] > 0) ? 1 : 0;
      n = pend_m[r] + inc - dec;
      pend_m[r] = (n > 3) ? 3 : n;
    end
    inc = (g && v.dw) ? 1 : 0;
    dec = (v.wbe && cc_m > 0) ? 1 : 0;
    n = cc_m + inc - dec;
    cc_m = (n > 7) ? 7 : n;
    if (sh_m > 0) sh_m = (v.res || sh_m == 1) ? 0 : sh_m - 1;
    else if (g && v.br) sh_m = 3;
  endfunction

  function automatic logic [15:0] model_mask();
    logic [15:0] m;
    for (int r = 0; r < 16; r++) m[r] = (pend_m[r] != 0);
    return m;
  endfunction

  task automatic drive(input vec_t v);
    I_RESET = v.rst; I_LOCK = v.lock; I_IssueValid = v.valid;
    I_Src1Used = v.s1u; I_Src1Idx = v.s1; I_Src2Used = v.s2u; I_Src2Idx = v.s2;
    I_DestWrite = v.dw; I_DestIdx = v.d; I_IsBranch = v.br; I_NeedsCC = v.ncc;
    I_WriteBackEnable = v.wbe; I_WriteBackRegIdx = v.wbi; I_BranchResolved = v.res;
  endtask

  // One cycle: drive after negedge, compare before the posedge, then advance the model
  task automatic step(input vec_t v, input bit use_tab, input string tag);
    bit eg, ed, eb;
    @(negedge I_CLOCK);
    drive(v);
    #1;
    model_comb(v, eg, ed, eb);
    chk({tag, ".grant"}, 32'(O_IssueGrant), 32'(eg));
    chk({tag, ".dep"},   32'(O_DepStallSignal), 32'(ed));
    chk({tag, ".brs"},   32'(O_BranchStallSignal), 32'(eb));
    chk({tag, ".mask"},  32'(O_PendingMask), 32'(model_mask()));
    chk({tag, ".err"},   32'(O_Error), 32'(err_m));
    if (use_tab) begin
      chk({tag, ".tab_grant"}, 32'(O_IssueGrant), 32'(v.e_grant));
      chk({tag, ".tab_dep"},   32'(O_DepStallSignal), 32'(v.e_dep));
      chk({tag, ".tab_brs"},   32'(O_BranchStallSignal), 32'(v.e_brs));
    end
    model_clock(v, eg);
  endtask

  task automatic do_reset();
    vec_t v;
    v = nop();
    v.rst = 1'b1;
    v.lock = 1'b0;
    step(v, 1'b0, "rst");
  endtask

  vec_t tab[9];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    int n;
    int gi;

    // Unchecked power-on reset so the DUT has defined state before comparisons start
    v = nop(); v.rst = 1'b1; v.lock = 1'b0;
    drive(v);
    repeat (2) @(negedge I_CLOCK);
    model_clock(v, 1'b0);

    // rst lock valid s1u s1 s2u s2 dw d br ncc wbe wbi res | grant dep brs
    tab[0] = mk(1,0,0, 0,0,0,0, 0,0, 0,0, 0,0,0, 0,0,0);
    tab[1] = mk(0,1,1, 1,2,1,3, 1,1, 0,0, 0,0,0, 1,0,0);
    tab[2] = mk(0,1,1, 1,1,1,2, 1,4, 0,0, 0,0,0, 0,1,0);
    tab[3] = mk(0,1,1, 1,1,1,2, 1,4, 0,0, 0,0,0, 0,1,0);
    tab[4] = mk(0,1,1, 1,1,1,2, 1,4, 0,0, 1,1,0, BYP ? 1 : 0, BYP ? 0 : 1, 0);
    tab[5] = mk(0,1,1, 1,1,1,2, 1,4, 0,0, 0,0,0, 1,0,0);
    tab[6] = mk(0,1,1, 0,0,0,0, 1,1, 0,0, 0,0,0, 1,0,0);
    tab[7] = mk(0,1,1, 0,0,0,0, 0,0, 1,1, 0,0,0, 0,1,1);
    tab[8] = mk(0,0,1, 0,0,0,0, 0,0, 1,1, 1,1,0, 0,0,0);
    for (int i = 0; i < 9; i++) step(tab[i], 1'b1, $sformatf("tab%0d", i));

    // MOVI R1 then BRZ: stalled on CC until R1 retires, then a 3-cycle shadow
    do_reset();
    step(op(0,0,0,0, 1,1, 0,0, 0,0), 1'b0, "movi");
    step(op(0,0,0,0, 0,0, 1,1, 0,0), 1'b0, "brz_wait");
    chk("brz_dep", 32'(O_DepStallSignal), 32'd1);
    chk("brz_brs", 32'(O_BranchStallSignal), 32'd1);
    gi = 99;
    for (int i = 0; i < 6; i++) begin
      step(op(0,0,0,0, 0,0, 1,1, (i == 0) ? 1 : 0, 1), 1'b0, "brz_try");
      if (O_IssueGrant === 1'b1) begin gi = i; break; end
    end
    chk("brz_grant_cycle", 32'(gi), BYP ? 32'd0 : 32'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      step(nop(), 1'b0, "shadow");
      if (O_BranchStallSignal === 1'b1) n++; else break;
    end
    chk("shadow_len", 32'(n), 32'd3);

    // Early resolution in the second shadow cycle
    step(op(0,0,0,0, 0,0, 1,0, 0,0), 1'b0, "jmp");
    chk("jmp_grant", 32'(O_IssueGrant), 32'd1);
    n = 0;
    for (int i = 0; i < 8; i++) begin
      v = nop(); v.res = (i == 1);
      step(v, 1'b0, "shadow_res");
      if (O_BranchStallSignal === 1'b1) n++; else break;
    end
    chk("shadow_res_len", 32'(n), 32'd2);

    // Saturation on R5, then simultaneous grant and retire to R5
    do_reset();
    repeat (3) step(op(0,0,0,0, 1,5, 0,0, 0,0), 1'b0, "r5_fill");
    step(op(0,0,0,0, 1,5, 0,0, 0,0), 1'b0, "r5_full");
    chk("r5_full_dep", 32'(O_DepStallSignal), 32'd1);
    step(op(0,0,0,0, 1,5, 0,0, 1,5), 1'b0, "r5_full_wb");
    chk("r5_full_wb_dep", 32'(O_DepStallSignal), 32'd1);
    step(op(0,0,0,0, 1,5, 0,0, 0,0), 1'b0, "r5_regrant");
    chk("r5_regrant", 32'(O_IssueGrant), 32'd1);
    step(op(0,0,0,0, 0,0, 0,0, 1,5), 1'b0, "r5_wb");
    step(op(0,0,0,0, 1,5, 0,0, 1,5), 1'b0, "r5_both");
    chk("r5_both_grant", 32'(O_IssueGrant), 32'd1);
    repeat (3) step(op(0,0,0,0, 0,0, 0,0, 1,5), 1'b0, "r5_drain");
    chk("r5_drained_err", 32'(O_Error), 32'd0);
    step(op(0,0,0,0, 0,0, 0,0, 1,5), 1'b0, "r5_extra");

    // Retire of an idle register sets a sticky error
    do_reset();
    step(op(0,0,0,0, 0,0, 0,0, 1,7), 1'b0, "wb_r7");
    repeat (4) step(nop(), 1'b0, "err_hold");
    chk("err_sticky", 32'(O_Error), 32'd1);
    chk("err_r7_mask", 32'(O_PendingMask), 32'd0);

    // Pipeline disabled: nothing moves and the decisions read zero
    do_reset();
    step(op(0,0,0,0, 1,2, 0,0, 0,0), 1'b0, "lock_setup");
    for (int i = 0; i < 4; i++) begin
      v = op(1,2,0,0, 0,0, 1,1, 1,2); v.lock = 1'b0;
      step(v, 1'b0, "locked");
    end
    chk("lock_mask", 32'(O_PendingMask), 32'h0004);
    chk("lock_err", 32'(O_Error), 32'd0);

    // Reset in the middle of a shadow with R3 pending twice
    do_reset();
    repeat (2) step(op(0,0,0,0, 1,3, 0,0, 0,0), 1'b0, "r3_fill");
    step(op(0,0,0,0, 0,0, 1,0, 0,0), 1'b0, "jmp2");
    step(nop(), 1'b0, "in_shadow");
    chk("in_shadow_brs", 32'(O_BranchStallSignal), 32'd1);
    v = nop(); v.rst = 1'b1;
    step(v, 1'b0, "mid_rst");
    step(nop(), 1'b0, "post_rst");
    chk("post_rst_mask", 32'(O_PendingMask), 32'd0);
    chk("post_rst_brs", 32'(O_BranchStallSignal), 32'd0);
    chk("post_rst_err", 32'(O_Error), 32'd0);

    // Random traffic over a small register window against the model
    for (int i = 0; i < 400; i++) begin
      v = nop();
      v.rst   = ($urandom_range(63) == 0);
      v.lock  = ($urandom_range(7) != 0);
      v.valid = $urandom_range(1) == 1;
      v.s1u   = $urandom_range(1) == 1;
      v.s1    = 4'($urandom_range(3));
      v.s2u   = $urandom_range(1) == 1;
      v.s2    = 4'($urandom_range(3));
      v.dw    = $urandom_range(1) == 1;
      v.d     = 4'($urandom_range(3));
      v.br    = ($urandom_range(7) == 0);
      v.ncc   = v.br && ($urandom_range(1) == 1);
      v.wbe   = ($urandom_range(2) == 0);
      v.wbi   = 4'($urandom_range(3));
      v.res   = ($urandom_range(3) == 0);
      step(v, 1'b0, "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
